shiftadd_mul_param: RTL and testbench

- Parametrised sequential shift-and-add multiplier. Successor to the fixed 4-bit shift-add unit.
- Generalised to WIDTH-bit operands, with a per-operation signed/unsigned mode.
- Uses a valid/ready handshake on both input and output, in place of a start/flag pulse.
- Performs the add and the shift in one cycle per multiplier bit, so latency is fixed and independent of data.
- Sits between the datapath's operand registers and the result writeback in the arithmetic block.

---
 rtl/shiftadd_mul_param.sv | 102 ++++++++++
 tb/tb_shiftadd_mul_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shiftadd_mul_param.sv
// Sequential shift-and-add multiplier with WIDTH-bit operands and per-operation signed mode.
// Valid/ready handshake on both sides. Latency is fixed: WIDTH add/shift cycles, then one sign-fix cycle.
module shiftadd_mul_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     mq_q, mq_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   r_q, r_d;

   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod_raw;

   always_comb begin
      state_d  = state_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      // The most negative operand's magnitude still fits as WIDTH-bit unsigned.
      a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
      sum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
      prod_raw = {acc_q, mq_q};

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               mcand_d = a_mag;
               mq_d    = b_mag;
               acc_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = CALC;
            end
         end
         CALC: begin
            // Carry lands in the accumulator MSB; the sum LSB shifts into the multiplier register.
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            r_d     = neg_q ? -prod_raw : prod_raw;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == CALC) || (state_q == FIX);
   assign product   = out_valid ? r_q : '0;

endmodule

// File: tb/tb_shiftadd_mul_param.sv
// Bench for shiftadd_mul_param: WIDTH=8 and WIDTH=4 instances against an arithmetic reference model.
module tb_shiftadd_mul_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv8, ir8, s8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv4, ir4, s4, ov4, or4, busy4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

   shiftadd_mul_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8));

   shiftadd_mul_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4));

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference product: plain integer multiply of the interpreted operands, wrapped to 2*w bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                           input logic s, input int w);
      longint x, y, msk;
      msk = (longint'(1) << w) - 1;
      x = longint'(av) & msk;
      y = longint'(bv) & msk;
      if (s && av[w-1]) x = x - (longint'(1) << w);
      if (s && bv[w-1]) y = y - (longint'(1) << w);
      return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Model state per instance: 0 = waiting for operands, 1 = computing, 2 = holding result.
   int          ph[2];
   int          wt[2];
   logic [63:0] ex[2];

   task automatic mstep(input int i, input logic iv, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input logic ordy, input int w);
      if (rst) begin
         ph[i] = 0; wt[i] = 0; ex[i] = '0;
      end else begin
         case (ph[i])
            0: if (iv) begin
                  ex[i] = ref_mul(av, bv, s, w);
                  wt[i] = w + 1;
                  ph[i] = 1;
               end
            1: begin
                  wt[i]--;
                  if (wt[i] == 0) ph[i] = 2;
               end
            default: if (ordy) ph[i] = 0;
         endcase
      end
   endtask

   always @(posedge clk) begin
      mstep(0, iv8, 32'(a8), 32'(b8), s8, or8, 8);
      mstep(1, iv4, 32'(a4), 32'(b4), s4, or4, 4);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready8",  64'(ir8),   64'(ph[0] == 0));
         chk("out_valid8", 64'(ov8),   64'(ph[0] == 2));
         chk("busy8",      64'(busy8), 64'(ph[0] == 1));
         chk("product8",   64'(p8),    (ph[0] == 2) ? ex[0] : 64'd0);
         chk("in_ready4",  64'(ir4),   64'(ph[1] == 0));
         chk("out_valid4", 64'(ov4),   64'(ph[1] == 2));
         chk("busy4",      64'(busy4), 64'(ph[1] == 1));
         chk("product4",   64'(p4),    (ph[1] == 2) ? ex[1] : 64'd0);
      end
   end

   function automatic logic get_ir(input int d);  return d ? ir4 : ir8; endfunction
   function automatic logic get_ov(input int d);  return d ? ov4 : ov8; endfunction
   function automatic logic [63:0] get_p(input int d); return d ? 64'(p4) : 64'(p8); endfunction

   task automatic set_in(input int d, input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic s);
      if (d != 0) begin iv4 = v; a4 = av[3:0]; b4 = bv[3:0]; s4 = s; end
      else        begin iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; s8 = s; end
   endtask

   task automatic set_or(input int d, input logic v);
      if (d != 0) or4 = v; else or8 = v;
   endtask

   // One full operation; lit_en pins the product to a hand-computed value.
   task automatic op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic s,
                     input logic lit_en, input logic [63:0] lit, input int stall);
      int n;
      int w;
      logic [63:0] exp;
      w = d ? 4 : 8;
      exp = ref_mul(av, bv, s, w);
      n = 0;
      while (!get_ir(d) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("ready_timeout", 64'd0, 64'd1);
      set_or(d, stall == 0);
      set_in(d, 1'b1, av, bv, s);
      @(negedge clk);
      set_in(d, 1'b0, $urandom, $urandom, 1'($urandom));
      n = 1;
      while (!get_ov(d) && n < 100) begin @(negedge clk); n++; end
      chk(d ? "latency4" : "latency8", 64'(n), 64'(w + 2));
      chk(d ? "result4" : "result8", get_p(d), exp);
      if (lit_en) chk(d ? "literal4" : "literal8", get_p(d), lit);
      for (int k = 0; k < stall; k++) begin
         set_in(d, 1'b1, $urandom, $urandom, 1'($urandom));
         @(negedge clk);
         chk("stall_product", get_p(d), exp);
         chk("stall_in_ready", 64'(get_ir(d)), 64'd0);
      end
      set_in(d, 1'b0, $urandom, $urandom, 1'($urandom));
      set_or(d, 1'b1);
      @(negedge clk);
      chk("drain_out_valid", 64'(get_ov(d)), 64'd0);
      chk("drain_in_ready", 64'(get_ir(d)), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 1'b0, 0, 0, 1'b0);
      set_in(1, 1'b0, 0, 0, 1'b0);
      or8 = 1'b1; or4 = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_in_ready", 64'(ir8), 64'd1);
      chk("reset_out_valid", 64'(ov8), 64'd0);
      chk("reset_product", 64'(p8), 64'd0);
      chk("reset_busy", 64'(busy8), 64'd0);

      chk("model_uu", ref_mul(32'hFF, 32'hFF, 1'b0, 8), 64'hFE01);
      chk("model_ss", ref_mul(32'h80, 32'h80, 1'b1, 8), 64'h4000);

      op(0, 32'hFF, 32'hFF, 1'b0, 1'b1, 64'hFE01, 0);
      op(0, 32'hFD, 32'h05, 1'b1, 1'b1, 64'hFFF1, 0);
      op(0, 32'h80, 32'h80, 1'b1, 1'b1, 64'h4000, 0);
      op(0, 32'h7F, 32'h80, 1'b1, 1'b1, 64'hC080, 0);
      op(0, 32'hFD, 32'h05, 1'b0, 1'b1, 64'h04F1, 0);
      op(0, 32'h00, 32'h80, 1'b1, 1'b1, 64'h0000, 0);
      op(0, 32'h5A, 32'h3C, 1'b0, 1'b1, 64'h1518, 6);

      // Reset during the 4th CALC cycle discards the operation.
      set_or(0, 1'b1);
      set_in(0, 1'b1, 32'h33, 32'h44, 1'b0);
      @(negedge clk);
      set_in(0, 1'b0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 64'(ir8), 64'd1);
      chk("midrst_out_valid", 64'(ov8), 64'd0);
      chk("midrst_product", 64'(p8), 64'd0);
      op(0, 32'd7, 32'd6, 1'b0, 1'b1, 64'h002A, 0);

      op(1, 32'd15, 32'd15, 1'b0, 1'b1, 64'hE1, 0);
      op(1, 32'd0, 32'd9, 1'b0, 1'b1, 64'h00, 0);
      op(1, 32'h8, 32'h8, 1'b1, 1'b1, 64'h40, 0);

      for (int i = 0; i < 30; i++)
         op(0, $urandom, $urandom, 1'($urandom), 1'b0, 64'd0, int'($urandom_range(0, 3)));
      for (int i = 0; i < 12; i++)
         op(1, $urandom, $urandom, 1'($urandom), 1'b0, 64'd0, int'($urandom_range(0, 2)));

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
